// File: rtl/axi4_lite_traffic_seq.sv
// rtl/axi4_lite_traffic_seq.sv - run controller for the AXI4-Lite memory traffic generator
// Sequences generator reset/start per pass, watches done/error/timeout and reports run status.
module axi4_lite_traffic_seq #(
   parameter int unsigned NUM_PASSES       = 4,
   parameter int unsigned GEN_RESET_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES   = 100000000,
   parameter int unsigned PASS_CNT_W       = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  go_i,
   input  logic                  abort_i,
   output logic                  gen_reset_n_o,
   output logic                  gen_start_o,
   input  logic                  gen_done_i,
   input  logic                  gen_wr_error_i,
   input  logic                  gen_rd_error_i,
   output logic                  busy_o,
   output logic                  pass_o,
   output logic                  fail_o,
   output logic [2:0]            fail_code_o,
   output logic [PASS_CNT_W-1:0] pass_count_o
);

   localparam int unsigned RST_W = $clog2(GEN_RESET_CYCLES);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [RST_W-1:0]      RST_LAST   = RST_W'(GEN_RESET_CYCLES - 1);
   localparam logic [TMO_W-1:0]      TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PASS_CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [PASS_CNT_W-1:0] CNT_TARGET = PASS_CNT_W'(NUM_PASSES);
   localparam bit                    FINITE     = (NUM_PASSES != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET_GEN,
      S_RUN,
      S_DONE,
      S_FAIL
   } state_t;

   state_t                  state_q, state_d;
   logic [RST_W-1:0]        rst_cnt_q, rst_cnt_d;
   logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic [PASS_CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
   logic [PASS_CNT_W-1:0]   pass_inc;
   logic [2:0]              fail_code_q, fail_code_d;
   logic                    go_prev_q;
   logic                    go_rise;
   logic                    gen_reset_n_q, gen_start_q, busy_q, pass_q, fail_q;

   assign go_rise  = go_i & ~go_prev_q;
   assign pass_inc = (pass_cnt_q == CNT_MAX) ? pass_cnt_q : pass_cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      pass_cnt_d  = pass_cnt_q;
      fail_code_d = fail_code_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (go_rise) begin
               state_d     = S_RESET_GEN;
               rst_cnt_d   = '0;
               pass_cnt_d  = '0;
               fail_code_d = '0;
            end
         end
         S_RESET_GEN: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (rst_cnt_q == RST_LAST) begin
               state_d   = S_RUN;
               tmo_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            // Priority: abort, then error, then done, then timeout.
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (gen_wr_error_i || gen_rd_error_i) begin
               state_d     = S_FAIL;
               fail_code_d = {1'b0, gen_rd_error_i, gen_wr_error_i};
            end else if (gen_done_i) begin
               pass_cnt_d = pass_inc;
               if (FINITE && (pass_inc == CNT_TARGET)) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_RESET_GEN;
                  rst_cnt_d = '0;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d     = S_FAIL;
               fail_code_d = 3'b100;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= S_IDLE;
         rst_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         pass_cnt_q    <= '0;
         fail_code_q   <= '0;
         go_prev_q     <= 1'b1;
         gen_reset_n_q <= 1'b0;
         gen_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         pass_cnt_q    <= pass_cnt_d;
         fail_code_q   <= fail_code_d;
         go_prev_q     <= go_i;
         gen_reset_n_q <= (state_d == S_RUN);
         gen_start_q   <= (state_d == S_RUN);
         busy_q        <= (state_d == S_RUN) || (state_d == S_RESET_GEN);
         pass_q        <= (state_d == S_DONE);
         fail_q        <= (state_d == S_FAIL);
      end
   end

   assign gen_reset_n_o = gen_reset_n_q;
   assign gen_start_o   = gen_start_q;
   assign busy_o        = busy_q;
   assign pass_o        = pass_q;
   assign fail_o        = fail_q;
   assign fail_code_o   = fail_code_q;
   assign pass_count_o  = pass_cnt_q;

endmodule

// File: tb/tb_axi4_lite_traffic_seq.sv
// tb/tb_axi4_lite_traffic_seq.sv - scoreboard bench for axi4_lite_traffic_seq
// Per-pass generator behaviour is planned up front; a reference model predicts each run's end status.
module tb_axi4_lite_traffic_seq;

   localparam int NP  = 3;
   localparam int RG  = 4;
   localparam int TMO = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, go, abort_gen, abort_stim, abort, done, wr_err, rd_err;
   logic        gen_reset_n, gen_start, busy, pass, fail;
   logic [2:0]  code;
   logic [15:0] pcnt;
   assign abort = abort_gen | abort_stim;

   logic        go2, abort2, done2, gen_reset_n2, gen_start2, busy2, pass2, fail2;
   logic [2:0]  code2;
   logic [1:0]  pcnt2;

   axi4_lite_traffic_seq #(.NUM_PASSES(NP), .GEN_RESET_CYCLES(RG), .TIMEOUT_CYCLES(TMO), .PASS_CNT_W(16)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .go_i(go), .abort_i(abort),
      .gen_reset_n_o(gen_reset_n), .gen_start_o(gen_start),
      .gen_done_i(done), .gen_wr_error_i(wr_err), .gen_rd_error_i(rd_err),
      .busy_o(busy), .pass_o(pass), .fail_o(fail), .fail_code_o(code), .pass_count_o(pcnt)
   );

   axi4_lite_traffic_seq #(.NUM_PASSES(0), .GEN_RESET_CYCLES(RG), .TIMEOUT_CYCLES(TMO), .PASS_CNT_W(2)) dut2 (
      .clk_i(clk), .reset_n_i(rst_n), .go_i(go2), .abort_i(abort2),
      .gen_reset_n_o(gen_reset_n2), .gen_start_o(gen_start2),
      .gen_done_i(done2), .gen_wr_error_i(1'b0), .gen_rd_error_i(1'b0),
      .busy_o(busy2), .pass_o(pass2), .fail_o(fail2), .fail_code_o(code2), .pass_count_o(pcnt2)
   );

   typedef enum int {K_DONE, K_WR, K_RD, K_WRRD, K_DONE_RD, K_TMO, K_DONE_TMO, K_ABORT} kind_e;
   typedef struct {
      kind_e kind;
      int    dly;
   } plan_t;
   typedef struct {
      logic       p;
      logic       f;
      logic [2:0] code;
      int         cnt;
   } exp_t;

   plan_t plan_q[$];
   exp_t  sb_q[$];
   exp_t  last_exp;
   kind_e run_k[$];
   int    run_d[$];
   int    total = 0;
   int    bad = 0;

   task automatic chk(input string name, input longint act, input longint want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   task automatic add(input kind_e k, input int d);
      run_k.push_back(k);
      run_d.push_back(d);
   endtask

   function automatic plan_t mk_plan(input kind_e k, input int d);
      plan_t p;
      p.kind = k;
      p.dly  = d;
      return p;
   endfunction

   function automatic exp_t mk_exp(input logic p, input logic f, input logic [2:0] c, input int n);
      exp_t e;
      e.p = p; e.f = f; e.code = c; e.cnt = n;
      return e;
   endfunction

   // Reference model: walk the planned passes and derive the run outcome.
   task automatic build_and_run();
      exp_t e;
      int   cnt = 0;
      bit   term = 0;
      int   n;
      e = mk_exp(1'b0, 1'b0, 3'b000, 0);
      for (int i = 0; i < run_k.size() && !term; i++) begin
         plan_q.push_back(mk_plan(run_k[i], run_d[i]));
         case (run_k[i])
            K_DONE, K_DONE_TMO: begin
               if (cnt < 65535) cnt++;
               if (cnt == NP) begin e.p = 1'b1; term = 1; end
            end
            K_WR:      begin e.f = 1'b1; e.code = 3'b001; term = 1; end
            K_RD:      begin e.f = 1'b1; e.code = 3'b010; term = 1; end
            K_DONE_RD: begin e.f = 1'b1; e.code = 3'b010; term = 1; end
            K_WRRD:    begin e.f = 1'b1; e.code = 3'b011; term = 1; end
            K_TMO:     begin e.f = 1'b1; e.code = 3'b100; term = 1; end
            default:   term = 1;
         endcase
      end
      e.cnt = cnt;
      sb_q.push_back(e);
      last_exp = e;
      run_k.delete();
      run_d.delete();
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0;
      n = 0;
      while (busy && n < 600) begin
         @(negedge clk);
         n++;
         go = (n == 7 && busy) ? 1'b1 : 1'b0;
      end
      go = 1'b0;
      chk("run_ends", busy, 0);
      @(negedge clk);
   endtask

   task automatic random_run();
      kind_e k;
      int    r;
      int    c = 0;
      bit    stop = 0;
      for (int i = 0; i <= NP && !stop; i++) begin
         r = $urandom_range(0, 99);
         if      (r < 50) k = K_DONE;
         else if (r < 57) k = K_WR;
         else if (r < 64) k = K_RD;
         else if (r < 70) k = K_WRRD;
         else if (r < 77) k = K_DONE_RD;
         else if (r < 84) k = K_TMO;
         else if (r < 90) k = K_DONE_TMO;
         else             k = K_ABORT;
         add(k, (k == K_DONE_TMO) ? TMO - 1 : int'($urandom_range(0, 50)));
         if (k == K_DONE || k == K_DONE_TMO) begin
            c++;
            if (c == NP) stop = 1;
         end else begin
            stop = 1;
         end
      end
      build_and_run();
   endtask

   // Generator model: on each start, play one planned pass; flags are sticky until generator reset.
   initial begin
      plan_t cur;
      int    k = 0;
      bit    active = 0;
      logic  prev_start = 1'b0;
      cur = mk_plan(K_TMO, 0);
      done = 1'b0; wr_err = 1'b0; rd_err = 1'b0; abort_gen = 1'b0;
      forever begin
         @(negedge clk);
         abort_gen = 1'b0;
         if (!gen_reset_n) begin done = 1'b0; wr_err = 1'b0; rd_err = 1'b0; end
         if (gen_start && !prev_start) begin
            cur = (plan_q.size() > 0) ? plan_q.pop_front() : mk_plan(K_TMO, 0);
            k = 0;
            active = 1;
         end else if (gen_start) begin
            k++;
         end
         if (!gen_start) active = 0;
         prev_start = gen_start;
         if (active && k == cur.dly) begin
            case (cur.kind)
               K_DONE, K_DONE_TMO: done = 1'b1;
               K_WR:      wr_err = 1'b1;
               K_RD:      rd_err = 1'b1;
               K_WRRD:    begin wr_err = 1'b1; rd_err = 1'b1; end
               K_DONE_RD: begin done = 1'b1; rd_err = 1'b1; end
               K_ABORT:   abort_gen = 1'b1;
               default:   ;
            endcase
         end
      end
   end

   initial begin
      int k2 = 0;
      done2 = 1'b0;
      forever begin
         @(negedge clk);
         if (!gen_reset_n2) done2 = 1'b0;
         if (gen_start2) k2++; else k2 = 0;
         if (k2 == 5) done2 = 1'b1;
      end
   end

   // Monitor: reset-window length, timeout latency, and end-of-run status against the scoreboard.
   initial begin
      exp_t e;
      logic busy_prev = 1'b0, rstn_prev = 1'b0, start_prev = 1'b0, fail_prev = 1'b0;
      int   rg_len = 0;
      int   cyc = 0;
      forever begin
         @(negedge clk);
         if (gen_start && !start_prev) cyc = 0; else cyc++;
         if (!busy) rg_len = 0;
         else if (!gen_reset_n) rg_len++;
         if (gen_reset_n && !rstn_prev) begin
            chk("reset_window", rg_len, RG);
            rg_len = 0;
         end
         if (fail && !fail_prev && code == 3'b100) chk("timeout_latency", cyc, TMO);
         if (!busy && busy_prev) begin
            if (sb_q.size() == 0) begin
               chk("sb_nonempty", 0, 1);
            end else begin
               e = sb_q.pop_front();
               chk("end_pass", pass, e.p);
               chk("end_fail", fail, e.f);
               chk("end_code", code, e.code);
               chk("end_count", pcnt, e.cnt);
               chk("end_gen_rst", gen_reset_n, 0);
               chk("pass_fail_excl", pass & fail, 0);
            end
         end
         busy_prev = busy; rstn_prev = gen_reset_n; start_prev = gen_start; fail_prev = fail;
      end
   end

   initial begin
      int n, starts;
      logic gs2_prev;
      rst_n = 1'b0; go = 1'b1; abort_stim = 1'b0; go2 = 1'b0; abort2 = 1'b0;
      last_exp = mk_exp(1'b0, 1'b0, 3'b000, 0);
      repeat (3) @(negedge clk);
      chk("rst_gen_rst", gen_reset_n, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("go_high_thru_reset", busy, 0);
      chk("rst_count", pcnt, 0);
      chk("rst_passfail", {pass, fail, code}, 0);
      go = 1'b0;
      @(negedge clk);

      add(K_DONE, 20); add(K_DONE, 20); add(K_DONE, 20); build_and_run();
      add(K_DONE, 20); add(K_WR, 10); build_and_run();
      add(K_DONE_RD, 15); build_and_run();
      add(K_TMO, 0); build_and_run();
      add(K_DONE_TMO, TMO - 1); add(K_DONE, 5); add(K_DONE, 5); build_and_run();
      add(K_DONE, 10); add(K_ABORT, 12); build_and_run();
      for (int r = 0; r < 25; r++) random_run();

      // Abort while idle must not disturb held status.
      @(negedge clk); abort_stim = 1'b1;
      @(negedge clk); abort_stim = 1'b0;
      @(negedge clk);
      chk("idle_abort_pass", pass, last_exp.p);
      chk("idle_abort_fail", fail, last_exp.f);
      chk("idle_abort_count", pcnt, last_exp.cnt);

      // Abort during the generator reset window.
      sb_q.push_back(mk_exp(1'b0, 1'b0, 3'b000, 0));
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0; abort_stim = 1'b1;
      @(negedge clk); abort_stim = 1'b0;
      @(negedge clk);
      chk("rg_abort_busy", busy, 0);

      // Asynchronous reset mid-pass with go held high.
      plan_q.push_back(mk_plan(K_DONE, 40));
      sb_q.push_back(mk_exp(1'b0, 1'b0, 3'b000, 0));
      @(negedge clk); go = 1'b1;
      n = 0;
      while (!gen_start && n < 50) begin @(negedge clk); n++; end
      chk("async_start_seen", gen_start, 1);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_gen_rst", gen_reset_n, 0);
      chk("async_gen_start", gen_start, 0);
      chk("async_busy", busy, 0);
      chk("async_status", {pass, fail, code}, 0);
      chk("async_count", pcnt, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("async_no_restart", busy, 0);
      chk("async_gen_held", gen_reset_n, 0);
      go = 1'b0;
      @(negedge clk);

      // Infinite mode, 2-bit counter saturates.
      go2 = 1'b1; @(negedge clk); go2 = 1'b0;
      starts = 0; n = 0; gs2_prev = 1'b0;
      while (starts < 6 && n < 2000) begin
         @(negedge clk);
         n++;
         if (gen_start2 && !gs2_prev) begin
            starts++;
            if (starts == 3) chk("inf_count2", pcnt2, 2);
         end
         gs2_prev = gen_start2;
      end
      chk("inf_starts", starts, 6);
      chk("inf_sat", pcnt2, 3);
      chk("inf_busy", busy2, 1);
      abort2 = 1'b1; @(negedge clk); abort2 = 1'b0; @(negedge clk);
      chk("inf_abort_busy", busy2, 0);
      chk("inf_abort_count", pcnt2, 3);
      chk("inf_abort_status", {pass2, fail2, code2}, 0);

      chk("sb_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
